pc: RTL and testbench
=====================

PC -- requirements
Module: pc

Interface
REQ-001 Psize, 6, PC width in bits; legal range 2..16.
REQ-002 RESET_VAL, 0, value loaded into PCout on reset; must fit in Psize bits.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 PCincr  input  1  increment request; PC advances only when high.
REQ-006 flag  input  1  hold/wait condition (external switch); while high the PC holds.
REQ-007 PCout  output  Psize  current program counter value, driven directly from the register.

Function
REQ-008 Single Psize-bit register PC; PCout SHALL equal PC at all times, with no combinational path from any input to PCout.
REQ-009 Priority on each rising clk edge SHALL be: reset, then hold, then increment.
- reset=1 -> PC <= RESET_VAL, regardless of PCincr or flag.
- reset=0, flag=1 -> PC holds.
- reset=0, flag=0, PCincr=1 -> PC <= PC+1.
- reset=0, flag=0, PCincr=0 -> PC holds.
REQ-010 Latency SHALL be one cycle: an increment sampled at edge N is visible on PCout after edge N.
REQ-011 Increment SHALL be unsigned modulo 2^Psize, so 2^Psize-1 wraps to 0 (unless REQ-017 applies).
REQ-012 flag and PCincr SHALL be sampled only at rising edges; glitches between edges have no effect.
REQ-013 Simultaneous flag=1 and PCincr=1 SHALL hold the PC (flag wins).

Reset
REQ-014 Reset SHALL be synchronous; asserting reset between edges SHALL not change PCout until the next rising edge.
REQ-015 Reset asserted mid-count SHALL load RESET_VAL on the next edge; while reset stays high, PC SHALL remain RESET_VAL.
REQ-016 After reset deasserts, counting SHALL resume on the first edge where flag=0 and PCincr=1.

Configuration
REQ-017 Macro PC_SATURATE_EN:
- When defined, an increment at 2^Psize-1 SHALL leave PC at 2^Psize-1.
- When undefined, the wrap of REQ-011 SHALL apply.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-018 Scenario 1, reset: reset=1 for 1 edge, PCincr=1, flag=0 -> PCout=0; release reset -> PCout = 1, 2, 3 on successive edges.
REQ-019 Scenario 2, hold: PCout=5, flag=1, PCincr=1 for 3 edges -> PCout stays 5; flag=0 -> 6 on next edge.
REQ-020 Scenario 3, idle: PCincr=0, flag=0 for 4 edges at PCout=9 -> stays 9.
REQ-021 Scenario 4, wrap: PCout=63 (Psize=6), increment -> 0; with PC_SATURATE_EN -> stays 63.
REQ-022 Scenario 5, mid-run reset: counting at PCout=20, reset=1 with flag toggling -> PCout=0 on next edge and stays 0 while reset=1.
REQ-023 Scenario 6, reset value: RESET_VAL=3, reset pulse -> PCout=3; then one increment -> 4.

Source files
------------

// File: rtl/pc.sv
// ---------------------------------------------------------------------------
// pc -- program counter register
//
// Purpose:
//   A single Psize-bit program counter. On every rising clock edge the
//   counter is reloaded, held or advanced by one, in that priority:
//     reset            -> RESET_VAL
//     flag             -> hold (flag also wins over PCincr)
//     PCincr           -> PC + 1
//     otherwise        -> hold
//   PCout comes straight from the register, so no input reaches it
//   combinationally. An increment sampled at edge N is visible after edge N.
//
// Parameters:
//   Psize      PC width in bits (legal range 2..16)
//   RESET_VAL  value loaded on reset (must fit in Psize bits)
//
// Ports:
//   clk     in   1      system clock, all state changes on the rising edge
//   reset   in   1      synchronous, active-high reset
//   PCincr  in   1      increment request
//   flag    in   1      hold/wait condition, holds the PC while high
//   PCout   out  Psize  current program counter value
//
// Build options:
//   PC_SATURATE_EN  when defined, an increment at the all-ones value leaves
//                   the PC at all-ones instead of wrapping to zero. All other
//                   behaviour is the same in both builds.
// ---------------------------------------------------------------------------
module pc #(
  parameter int               Psize     = 6,
  parameter logic [Psize-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCincr,
  input  logic             flag,
  output logic [Psize-1:0] PCout
);

  localparam logic [Psize-1:0] PC_ONE = Psize'(1);
  localparam logic [Psize-1:0] PC_MAX = '1;

  logic [Psize-1:0] pc_q;
  logic [Psize-1:0] pc_next;
  logic             advance;

  // flag has priority over PCincr, so a simultaneous request holds.
  assign advance = PCincr & ~flag;

  always_comb begin
    pc_next = pc_q;
    if (advance) begin
`ifdef PC_SATURATE_EN
      // Stick at the top value rather than rolling over.
      if (pc_q != PC_MAX) begin
        pc_next = pc_q + PC_ONE;
      end
`else
      // Plain modulo-2^Psize increment; all-ones rolls over to zero.
      pc_next = pc_q + PC_ONE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VAL;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign PCout = pc_q;

endmodule

// File: tb/tb_pc.sv
// ---------------------------------------------------------------------------
// tb_pc -- self-checking bench for pc
//
// Two instances: u_dut with the default RESET_VAL of 0, and u_dut3 with
// RESET_VAL of 3. Inputs change on the falling edge; outputs are sampled
// 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_pc;

  localparam int PSIZE = 6;
  localparam int MODV  = 1 << PSIZE;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset  = 1'b1;
  logic             PCincr = 1'b0;
  logic             flag   = 1'b0;
  logic [PSIZE-1:0] PCout;

  logic             reset3  = 1'b1;
  logic             PCincr3 = 1'b0;
  logic             flag3   = 1'b0;
  logic [PSIZE-1:0] PCout3;

  pc #(.Psize(PSIZE), .RESET_VAL(6'd0)) u_dut (
    .clk(clk), .reset(reset), .PCincr(PCincr), .flag(flag), .PCout(PCout)
  );

  pc #(.Psize(PSIZE), .RESET_VAL(6'd3)) u_dut3 (
    .clk(clk), .reset(reset3), .PCincr(PCincr3), .flag(flag3), .PCout(PCout3)
  );

  // ---------------- reference model ----------------
  // The counter as a plain integer, advanced by the priority rules.
  int model_pc = 0;

  function automatic int model_next(int cur, bit r, bit i, bit f, int rv);
    if (r) return rv;
    if (f || !i) return cur;
`ifdef PC_SATURATE_EN
    if (cur == MODV - 1) return cur;
`endif
    return (cur + 1) % MODV;
  endfunction

  // ---------------- scoreboard ----------------
  logic [PSIZE-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [PSIZE-1:0] act,
                       input logic [PSIZE-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: PCout=%0d expected=%0d", name, act, exp);
  endtask

  task automatic check_sb(input string name);
    logic [PSIZE-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL %s: PCout=%0d expected=<empty queue>", name, PCout);
    end else begin
      e = exp_q.pop_front();
      check(name, PCout, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one set of inputs for one rising edge of u_dut; the model follows
  // the same edge. Returns 1 ns after the edge.
  task automatic drive_edge(input bit r, input bit i, input bit f);
    @(negedge clk);
    reset = r; PCincr = i; flag = f;
    @(posedge clk);
    model_pc = model_next(model_pc, r, i, f, 0);
    #1;
  endtask

  task automatic drive_edge3(input bit r, input bit i, input bit f);
    @(negedge clk);
    reset3 = r; PCincr3 = i; flag3 = f;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit               r;
    bit               i;
    bit               f;
    logic [PSIZE-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit r, input bit i, input bit f, input int exp);
    vec_t v;
    v.r = r; v.i = i; v.f = f; v.exp = PSIZE'(exp);
    vecs.push_back(v);
  endtask

  initial begin
    logic [PSIZE-1:0] hold_val;
    logic [PSIZE-1:0] wrap_exp;

    // Reset, then count 1,2,3
    add_vec(1, 1, 0, 0);
    add_vec(0, 1, 0, 1);
    add_vec(0, 1, 0, 2);
    add_vec(0, 1, 0, 3);
    add_vec(0, 1, 0, 4);
    add_vec(0, 1, 0, 5);
    // Hold at 5 with flag and PCincr both high, then release
    add_vec(0, 1, 1, 5);
    add_vec(0, 1, 1, 5);
    add_vec(0, 1, 1, 5);
    add_vec(0, 1, 0, 6);
    add_vec(0, 1, 0, 7);
    add_vec(0, 1, 0, 8);
    add_vec(0, 1, 0, 9);
    // Idle at 9
    add_vec(0, 0, 0, 9);
    add_vec(0, 0, 0, 9);
    add_vec(0, 0, 0, 9);
    add_vec(0, 0, 0, 9);
    // flag alone holds too
    add_vec(0, 0, 1, 9);
    add_vec(0, 1, 0, 10);

    for (int k = 0; k < vecs.size(); k++) begin
      drive_edge(vecs[k].r, vecs[k].i, vecs[k].f);
      check($sformatf("vec%0d", k), PCout, vecs[k].exp);
    end

    // Reset asserted between edges must not change PCout before the edge.
    @(negedge clk);
    hold_val = PCout;
    reset = 1'b1; PCincr = 1'b1; flag = 1'b0;
    #1;
    check("sync_reset_before_edge", PCout, hold_val);
    @(posedge clk);
    model_pc = 0;
    #1;
    check("sync_reset_after_edge", PCout, 6'd0);

    // Glitch on PCincr between edges has no effect.
    drive_edge(0, 0, 0);
    check("idle_after_reset", PCout, 6'd0);
    @(negedge clk);
    PCincr = 1'b1;
    #2;
    PCincr = 1'b0;
    @(posedge clk);
    #1;
    check("glitch_ignored", PCout, 6'd0);

    // Mid-run reset: count to 20, then reset with flag toggling.
    for (int k = 0; k < 20; k++) drive_edge(0, 1, 0);
    check("count_to_20", PCout, 6'd20);
    for (int k = 0; k < 3; k++) begin
      drive_edge(1, 1, bit'(k % 2));
      check($sformatf("midrun_reset%0d", k), PCout, 6'd0);
    end
    // Counting resumes on the first edge with flag=0 and PCincr=1.
    drive_edge(0, 1, 1);
    check("post_reset_flag_hold", PCout, 6'd0);
    drive_edge(0, 1, 0);
    check("post_reset_resume", PCout, 6'd1);

    // Wrap / saturate at the top value.
    drive_edge(1, 0, 0);
    for (int k = 0; k < MODV - 1; k++) drive_edge(0, 1, 0);
    check("reach_max", PCout, 6'd63);
    drive_edge(0, 1, 0);
`ifdef PC_SATURATE_EN
    wrap_exp = 6'd63;
`else
    wrap_exp = 6'd0;
`endif
    check("wrap_or_saturate", PCout, wrap_exp);
    drive_edge(0, 1, 1);
    check("hold_after_top", PCout, wrap_exp);

    // Non-zero reset value on the second instance.
    drive_edge3(1, 1, 0);
    check("rv3_reset", PCout3, 6'd3);
    drive_edge3(1, 1, 1);
    check("rv3_reset_held", PCout3, 6'd3);
    drive_edge3(0, 1, 0);
    check("rv3_incr", PCout3, 6'd4);
    drive_edge3(0, 0, 0);
    check("rv3_idle", PCout3, 6'd4);

    // Randomised run against the model.
    drive_edge(1, 0, 0);
    for (int k = 0; k < 400; k++) begin
      bit r, i, f;
      r = ($urandom_range(0, 24) == 0);
      i = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 3) == 0);
      drive_edge(r, i, f);
      exp_q.push_back(PSIZE'(model_pc));
      check_sb($sformatf("rand%0d", k));
    end

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
